// File: rtl/seq_divider8.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock through a
// gate-level ripple subtractor, with a start/done handshake and held results.
module seq_divider8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;

  // The stored partial remainder is always below D, so its top bit of the
  // WIDTH+1-bit value is zero; the full width only exists after the shift.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_b;
  logic [WIDTH:0]   w_t;
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_r_next;

  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_b     = ~{1'b0, r_div};
  assign w_c[0]  = 1'b1;

  // Ripple subtractor T = shifted R + ~D + 1 built from per-bit gate equations.
  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    assign w_t[i] = w_shift[i] ^ w_b[i] ^ w_c[i];
    if (i < WIDTH) begin : g_carry
      assign w_c[i+1] = (w_shift[i] & w_b[i]) | (w_c[i] & (w_shift[i] ^ w_b[i]));
    end
  end

  assign w_q_next = {r_quo[WIDTH-2:0], ~w_t[WIDTH]};
  assign w_r_next = w_t[WIDTH] ? w_shift[WIDTH-1:0] : w_t[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              r_state     <= S_DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_div   <= divisor;
              r_rem   <= '0;
              r_quo   <= dividend;
              r_cnt   <= CW'(WIDTH);
            end
          end
        end
        S_RUN: begin
          r_quo <= w_q_next;
          r_rem <= w_r_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state     <= S_DONE;
            done        <= 1'b1;
            quotient    <= w_q_next;
            remainder   <= w_r_next;
            div_by_zero <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider8.sv
// Scoreboard bench for seq_divider8: expected results are queued at start and
// compared when done pulses; also checks latency, busy length, hold and reset.
module tb_seq_divider8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] last_q   = '0;
  logic [7:0] last_r   = '0;
  logic       last_z   = 1'b0;

  seq_divider8 #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (!reset && done) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
        last_q = e.q;
        last_r = e.r;
        last_z = e.z;
      end
    end
  end

  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         input int pulse_at, input int rst_at);
    exp_t e;
    int   n;
    int   busy_cnt;
    int   lat;
    e.q = (b == 0) ? 8'hFF : 8'(a / b);
    e.r = (b == 0) ? a : 8'(a % b);
    e.z = (b == 0);
    lat = (b == 0) ? 0 : 8;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    n        = 0;
    busy_cnt = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      chk("hold_outputs", {quotient, remainder, 7'd0, div_by_zero},
          {last_q, last_r, 7'd0, last_z});
      if (n == rst_at) begin
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_abort", {busy, done, div_by_zero, quotient, remainder}, '0);
        sb.delete();
        last_q = '0;
        last_r = '0;
        last_z = 1'b0;
        return;
      end
      if (n == pulse_at) begin
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (busy) busy_cnt++;
    chk("done_latency", 32'(n), 32'(lat));
    chk("busy_cycles", 32'(busy_cnt), 32'(lat + 1));
    @(negedge clk);
    chk("idle_after_done", {busy, done}, 2'b00);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {busy, done, div_by_zero, quotient, remainder}, '0);
    reset = 1'b0;

    run_div(8'd100, 8'd7, -1, -1);
    run_div(8'd255, 8'd1, -1, -1);
    run_div(8'd5, 8'd9, -1, -1);
    run_div(8'd255, 8'd255, -1, -1);
    run_div(8'd200, 8'd0, -1, -1);
    run_div(8'd50, 8'd3, 4, -1);
    run_div(8'd100, 8'd7, -1, 5);
    run_div(8'd20, 8'd6, -1, -1);

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      run_div(a, b, -1, -1);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
